// File: rtl/serial_mult_ctrl.sv
// Bit-serial shift-and-add unsigned multiplier. A single full-adder slice and
// carry flop produce every partial-product bit, giving a fixed WIDTH*(WIDTH+1) cycle latency.
module serial_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     m_q, a_q, q_q;
  logic                 c_q;
  logic [CW-1:0]        bit_cnt_q, iter_cnt_q;
  logic                 busy_q, done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic                 addend_d, sum_d, carry_d;
  logic [WIDTH-1:0]     a_shift_d, q_shift_d;

  // The one full-adder slice shared by every bit of every partial product.
  assign addend_d = m_q[0] & q_q[0];
  assign sum_d    = a_q[0] ^ addend_d ^ c_q;
  assign carry_d  = (a_q[0] & addend_d) | (a_q[0] & c_q) | (addend_d & c_q);

  // {C,A,Q} logical right shift by one, carry cleared.
  assign a_shift_d = {c_q, a_q[WIDTH-1:1]};
  assign q_shift_d = {a_q[0], q_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      m_q        <= '0;
      a_q        <= '0;
      q_q        <= '0;
      c_q        <= 1'b0;
      bit_cnt_q  <= '0;
      iter_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      product_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q        <= a;
            q_q        <= b;
            a_q        <= '0;
            c_q        <= 1'b0;
            bit_cnt_q  <= '0;
            iter_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ADD;
          end
        end
        ADD: begin
          // Full WIDTH rotations every pass, so M returns to its original value.
          a_q <= {sum_d, a_q[WIDTH-1:1]};
          m_q <= {m_q[0], m_q[WIDTH-1:1]};
          c_q <= carry_d;
          if (bit_cnt_q == LAST) begin
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        SHIFT: begin
          c_q <= 1'b0;
          a_q <= a_shift_d;
          q_q <= q_shift_d;
          if (iter_cnt_q == LAST) begin
            iter_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            product_q  <= {a_shift_d, q_shift_d};
            state_q    <= DONE;
          end else begin
            iter_cnt_q <= iter_cnt_q + CW'(1);
            state_q    <= ADD;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Directed bench for serial_mult_ctrl (WIDTH=8): latency, products, ignored
// starts, asynchronous reset abort and back-to-back operation.
module tb_serial_mult_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;

  int total = 0;
  int bad   = 0;

  serial_mult_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One multiply; optionally pulses start (a=1,b=1) inject_at edges after acceptance.
  task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, input int inject_at,
                        input logic [15:0] expp, input string tag);
    int n;
    int busy_cnt;
    bit got;
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    n = 0; got = 0;
    busy_cnt = busy ? 1 : 0;
    while (!got && n < 200) begin
      if (n == inject_at) begin
        start = 1'b1; a = 8'd1; b = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
      else if (busy) busy_cnt++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, n, 72);
    chk({tag, "_busy_cycles"}, busy_cnt, 72);
    chk({tag, "_product"}, {16'd0, product}, {16'd0, expp});
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse_width"}, {31'd0, done}, 0);
    chk({tag, "_product_held"}, {16'd0, product}, {16'd0, expp});
    $display("op %s: a=%0d b=%0d product=%0d latency=%0d", tag, aa, bb, product, n);
  endtask

  logic [7:0]  a_arr [0:221];
  logic [7:0]  b_arr [0:221];
  logic [15:0] e;
  int ndone;
  int dcnt;

  initial begin
    reset = 1'b0; start = 1'b0; a = '0; b = '0;
    #3;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_product", {16'd0, product}, 0);
    @(negedge clk);
    reset = 1'b1;

    run_op(8'd3,    8'd5,    -1, 16'd15,    "3x5");
    run_op(8'd255,  8'd255,  -1, 16'hFE01,  "255x255");
    run_op(8'hAB,   8'd0,    -1, 16'd0,     "ABx0");
    run_op(8'd0,    8'hAB,   -1, 16'd0,     "0xAB");
    run_op(8'd7,    8'd9,    20, 16'd63,    "7x9_ignore_start");
    run_op(8'd128,  8'd2,    -1, 16'd256,   "128x2");

    // Abort at cycle 30 with an asynchronous reset between clock edges.
    @(negedge clk);
    a = 8'd200; b = 8'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("abort_busy_before", {31'd0, busy}, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_product", {16'd0, product}, 0);
    @(negedge clk);
    reset = 1'b1;
    dcnt = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    $display("op abort: reset at cycle 30, done pulses afterwards=%0d", dcnt);
    run_op(8'd12, 8'd12, -1, 16'd144, "12x12_after_reset");

    // Back-to-back with start held high and operands changing every cycle.
    ndone = 0;
    for (int i = 0; i < 222; i++) begin
      @(negedge clk);
      a_arr[i] = 8'($urandom);
      b_arr[i] = 8'($urandom);
      a = a_arr[i]; b = b_arr[i]; start = 1'b1;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        chk("b2b_done_cycle", i % 74, 72);
        if (i >= 72) begin
          e = 16'(a_arr[i-72]) * 16'(b_arr[i-72]);
          chk("b2b_product", {16'd0, product}, {16'd0, e});
          $display("op b2b: edge=%0d a=%0d b=%0d product=%0d", i, a_arr[i-72], b_arr[i-72], product);
        end
      end
    end
    start = 1'b0;
    chk("b2b_done_count", ndone, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_mult_ctrl.md
SERIAL_MULT_CTRL -- requirements
Module: serial_mult_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  multiplicand, unsigned, captured on accepted start.
REQ-006 b  input  WIDTH  multiplier, unsigned, captured on accepted start.
REQ-007 busy  output  1  high in ADD and SHIFT states.
REQ-008 done  output  1  one-cycle pulse, product valid.
REQ-009 product  output  2*WIDTH  unsigned a*b; held stable from done until next accepted start.

Function
REQ-010 Datapath SHALL be bit-serial: one 1-bit full-adder slice (sum = x^y^c, carry = majority) plus one carry flop, reused for every bit of every partial product.
REQ-011 Internal registers SHALL be: M (WIDTH, multiplicand), A (WIDTH, accumulator), Q (WIDTH, multiplier/low product), C (1, carry), bit counter (0..WIDTH-1), iteration counter (0..WIDTH-1).
REQ-012 FSM states SHALL be IDLE, ADD, SHIFT, DONE.
REQ-013 IDLE: start=1 -> M<=a, Q<=b, A<=0, C<=0, both counters<=0, next ADD; start=0 -> stay, all registers hold.
REQ-014 ADD, each cycle: addend bit = M[0] & Q[0]; sum of A[0], addend bit, C; A rotates right with sum entering A[WIDTH-1]; M rotates right; C <= carry; bit counter increments.
REQ-015 ADD lasts exactly WIDTH cycles regardless of Q[0] (fixed latency); after WIDTH rotations M is restored to its original value.
REQ-016 ADD -> SHIFT when bit counter = WIDTH-1; bit counter wraps to 0.
REQ-017 SHIFT (1 cycle): {C,A,Q} <= {1'b0, C, A, Q[WIDTH-1:1]}, i.e. 2W+1-bit logical right shift with C cleared; iteration counter increments.
REQ-018 SHIFT -> ADD if iteration counter < WIDTH-1, else -> DONE.
REQ-019 DONE (1 cycle): done=1, product={A,Q}; next IDLE unconditionally; start in DONE is ignored.
REQ-020 Latency: done SHALL be high in the cycle following exactly WIDTH*(WIDTH+1) rising edges after the edge that accepted start (WIDTH=8: 72 edges).
REQ-021 start while busy or in DONE SHALL be ignored; a, b changes after acceptance SHALL not affect the result.
REQ-022 product SHALL be driven from a register updated only on entry to DONE; no intermediate values visible on product.
REQ-023 No overflow possible: the 2*WIDTH product of two WIDTH-bit unsigned operands is exact.

Reset
REQ-024 reset=0 SHALL immediately (no clock needed) force state=IDLE, busy=0, done=0, product=0, and M, A, Q, C, counters to 0.
REQ-025 Reset asserted mid-operation SHALL abort the multiply; no done pulse for the aborted operation; the next start after release begins a fresh full-latency operation.
REQ-026 After reset deasserts, the first rising edge SHALL sample start in IDLE.

Verification
REQ-027 WIDTH=8, a=3, b=5, start 1 cycle -> busy high 72 cycles, done pulse at cycle 72, product=15.
REQ-028 a=255, b=255 -> product=65025 (0xFE01), latency 72.
REQ-029 a=0xAB, b=0 and a=0, b=0xAB -> product=0, latency still 72.
REQ-030 a=7, b=9 accepted, then start pulsed with a=1,b=1 at cycle 20 -> ignored, product=63.
REQ-031 reset=0 at cycle 30 of an operation -> busy, done, product go 0 asynchronously; restart with a=12, b=12 -> product=144 after 72 edges.
REQ-032 Back-to-back: start held high continuously with random operands -> one accepted every 74 cycles (IDLE, 72 ADD/SHIFT, DONE), each product equal to a*b of the captured operands.
